key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Debounces and synchronises the raw active-low push-button KEY1 into a clean, glitch-free level, `key1_stable`. That level directly clocks the odometer BCD counter.
- Also produces single-cycle press and release strobes for system-clock logic.
- Sits between the board pin and the odometer stage, on the 50 MHz board clock.
- Reset comes from KEY0, the same reset that clears the odometer.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 19, width of the stability counter. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk_sys  input  1  board system clock (50 MHz). The only clock in the block.
- rst_n_key0  input  1  asynchronous active-low reset from KEY0.
- key1_n_raw  input  1  raw KEY1 pin. Active-low (0 = pressed), asynchronous, bouncy.
- key1_stable  output  1  debounced level, 1 = pressed. Feeds the odometer clock input.
- key1_press  output  1  one clk_sys-cycle strobe on an accepted press.
- key1_release  output  1  one clk_sys-cycle strobe on an accepted release.

Behaviour:
- Interface: one clock, clk_sys. Reset rst_n_key0 is asynchronous and active-low. All flops clear on its negedge, independent of clk_sys.
- Reset values:
  - sync flops = 1 (released)
  - state = RELEASED
  - counter = 0
  - key1_stable = 0, key1_press = 0, key1_release = 0
- Synchroniser: 2-flop chain on key1_n_raw. Only the second flop output (key_s) is used downstream.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Counter `cnt` is CNT_W bits.
  - RELEASED: if key_s==0, go to PRESS_CHK and set cnt=0. Otherwise stay.
  - PRESS_CHK, key_s==1: bounce. Go to RELEASED, cnt=0.
  - PRESS_CHK, key_s==0 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, key1_stable<=1, key1_press<=1 for one cycle.
  - PRESS_CHK, otherwise: cnt<=cnt+1.
  - PRESSED: if key_s==1, go to RELEASE_CHK and set cnt=0. Otherwise stay.
  - RELEASE_CHK, key_s==0: bounce. Go to PRESSED, cnt=0.
  - RELEASE_CHK, key_s==1 and cnt==DEBOUNCE_CYCLES-1: go to RELEASED, key1_stable<=0, key1_release<=1 for one cycle.
  - RELEASE_CHK, otherwise: cnt<=cnt+1.
- Latency: a raw level held constant from sampling edge E0 makes key1_stable change at edge E0+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting E0. Strobes coincide with the key1_stable change.
- Glitch rejection: any synchronised excursion shorter than DEBOUNCE_CYCLES cycles produces no change on key1_stable and no strobe.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is only meaningful in the *_CHK states.
- key1_stable is a registered output driven straight from a flop, so the odometer sees a glitch-free clock edge. No combinational logic sits on this output.
- key1_press and key1_release are never high together and never high in consecutive cycles.
- Reset mid-operation (any state, any cnt) returns everything to the reset values immediately.
  - If the key is still held after reset deasserts, a full press qualification is needed before key1_stable rises.
- Illegal or unreachable state encodings recover to RELEASED on the next clk_sys edge.

Decomposition:
- Shared package key_pkg holds:
  - state enumeration: RELEASED=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3
  - DEBOUNCE_CYCLES default constant (50 MHz, 10 ms)
  - CNT_W derivation helper
- One natural sub-module, sync_2ff: generic 2-flop synchroniser with a reset-value parameter (here 1). It is reusable for the KEY0 path later.
- The FSM and counter stay in key_debounce.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4):
- Reset then idle: assert rst_n_key0=0, release, hold key1_n_raw=1 for 50 cycles -> key1_stable=0 throughout, no strobes.
- Clean press: key1_n_raw 1->0 at edge E0 and held -> key1_stable=1 and key1_press=1 for exactly one cycle at E0+10. key1_release stays 0.
- Bounce rejection: after 0, pulse key1_n_raw 0 for 5 cycles then 1, repeated 4 times -> key1_stable stays 0, no strobes. Then hold 0 -> key1_stable rises 11 edges after the last 1->0 transition.
- Release with bounce: from PRESSED, toggle 1/0 with 3-cycle periods, then hold 1 -> key1_release exactly once, key1_stable=0 only after 8 stable synchronised cycles.
- Odometer chain: connect key1_stable to odo_counter clk_key1 and apply 12 clean press/release pairs -> units=2, tens=1, huns=0.
- Mid-qualify reset: reach PRESS_CHK with cnt=5, assert rst_n_key0 asynchronously between clock edges -> all outputs 0 immediately. Key still held after reset deasserts -> key1_stable rises 11 edges later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the KEY1 debounce path.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;

  // 10 ms at the 50 MHz board clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 is enough.
  function automatic int cnt_width(input int cycles);
    if (cycles < 2) begin
      return 1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Both flops clear to RST_VAL so the idle level is seen during and after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces the active-low KEY1 pin into a registered level (clock for the
// odometer) plus single-cycle press/release strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk_sys,
  input  logic rst_n_key0,
  input  logic key1_n_raw,
  output logic key1_stable,
  output logic key1_press,
  output logic key1_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_key1 (
    .clk_i  (clk_sys),
    .rst_ni (rst_n_key0),
    .d_i    (key1_n_raw),
    .q_o    (key_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk_sys or negedge rst_n_key0) begin
    if (!rst_n_key0) begin
      state_q   <= RELEASED;
      cnt_q     <= CNT_ZERO;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing synchronised samples.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = RELEASED;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          stable_d = 1'b1;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = PRESSED;
        end
      end
      RELEASE_CHK: begin
        if (!key_s) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          stable_d  = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = RELEASED;
        cnt_d    = CNT_ZERO;
        stable_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from flops so the odometer clock is glitch-free.
  assign key1_stable  = stable_q;
  assign key1_press   = press_q;
  assign key1_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, CNT_W=4.
module tb_key_debounce;

  logic clk_sys;
  logic rst_n_key0;
  logic key1_n_raw;
  logic key1_stable;
  logic key1_press;
  logic key1_release;

  int total = 0;
  int bad   = 0;

  logic [3:0] odo_units, odo_tens, odo_huns;

  key_debounce #(
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n_key0   (rst_n_key0),
    .key1_n_raw   (key1_n_raw),
    .key1_stable  (key1_stable),
    .key1_press   (key1_press),
    .key1_release (key1_release)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Reference odometer stage: 3-digit BCD counter clocked by key1_stable.
  always_ff @(posedge key1_stable or negedge rst_n_key0) begin
    if (!rst_n_key0) begin
      odo_units <= 4'd0;
      odo_tens  <= 4'd0;
      odo_huns  <= 4'd0;
    end else if (odo_units != 4'd9) begin
      odo_units <= odo_units + 4'd1;
    end else begin
      odo_units <= 4'd0;
      if (odo_tens != 4'd9) begin
        odo_tens <= odo_tens + 4'd1;
      end else begin
        odo_tens <= 4'd0;
        odo_huns <= (odo_huns == 4'd9) ? 4'd0 : odo_huns + 4'd1;
      end
    end
  end

  task automatic test_reset();
    rst_n_key0 = 1'b0;
    key1_n_raw = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000", {key1_stable, key1_press, key1_release});
    end
    @(negedge clk_sys);
    rst_n_key0 = 1'b1;
  endtask

  task automatic test_idle();
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk_sys); #1;
      total++;
      if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
        bad++;
        $display("FAIL idle cycle=%0d got=%b want=000", k, {key1_stable, key1_press, key1_release});
      end
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk_sys);
    key1_n_raw = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      logic exp_st, exp_pr;
      @(posedge clk_sys); #1;
      exp_st = (k >= 11);
      exp_pr = (k == 11);
      total++;
      if ({key1_stable, key1_press, key1_release} !== {exp_st, exp_pr, 1'b0}) begin
        bad++;
        $display("FAIL clean_press edge=%0d got=%b want=%b", k,
                 {key1_stable, key1_press, key1_release}, {exp_st, exp_pr, 1'b0});
      end
    end
  endtask

  task automatic test_clean_release();
    @(negedge clk_sys);
    key1_n_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic exp_st, exp_rl;
      @(posedge clk_sys); #1;
      exp_st = (k < 11);
      exp_rl = (k == 11);
      total++;
      if ({key1_stable, key1_press, key1_release} !== {exp_st, 1'b0, exp_rl}) begin
        bad++;
        $display("FAIL clean_release edge=%0d got=%b want=%b", k,
                 {key1_stable, key1_press, key1_release}, {exp_st, 1'b0, exp_rl});
      end
    end
  endtask

  task automatic test_bounce_press();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk_sys);
      key1_n_raw = 1'b0;
      repeat (5) begin
        @(posedge clk_sys); #1;
        total++;
        if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
          bad++;
          $display("FAIL bounce_low round=%0d got=%b want=000", r, {key1_stable, key1_press, key1_release});
        end
      end
      @(negedge clk_sys);
      key1_n_raw = 1'b1;
      repeat (3) begin
        @(posedge clk_sys); #1;
        total++;
        if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
          bad++;
          $display("FAIL bounce_high round=%0d got=%b want=000", r, {key1_stable, key1_press, key1_release});
        end
      end
    end
    @(negedge clk_sys);
    key1_n_raw = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      logic exp_st, exp_pr;
      @(posedge clk_sys); #1;
      exp_st = (k >= 11);
      exp_pr = (k == 11);
      total++;
      if ({key1_stable, key1_press, key1_release} !== {exp_st, exp_pr, 1'b0}) begin
        bad++;
        $display("FAIL bounce_hold edge=%0d got=%b want=%b", k,
                 {key1_stable, key1_press, key1_release}, {exp_st, exp_pr, 1'b0});
      end
    end
  endtask

  task automatic test_bounce_release();
    int rel_seen = 0;
    for (int r = 0; r < 3; r++) begin
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk_sys);
        key1_n_raw = (ph == 0) ? 1'b1 : 1'b0;
        repeat (3) begin
          @(posedge clk_sys); #1;
          total++;
          if ({key1_stable, key1_press, key1_release} !== 3'b100) begin
            bad++;
            $display("FAIL rel_bounce round=%0d got=%b want=100", r, {key1_stable, key1_press, key1_release});
          end
        end
      end
    end
    @(negedge clk_sys);
    key1_n_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic exp_st;
      @(posedge clk_sys); #1;
      exp_st = (k < 11);
      if (key1_release === 1'b1) rel_seen++;
      total++;
      if ({key1_stable, key1_press} !== {exp_st, 1'b0}) begin
        bad++;
        $display("FAIL rel_hold edge=%0d got=%b want=%b", k, {key1_stable, key1_press}, {exp_st, 1'b0});
      end
    end
    total++;
    if (rel_seen != 1) begin
      bad++;
      $display("FAIL rel_strobe_count got=%0d want=1", rel_seen);
    end
  endtask

  task automatic test_odometer();
    int presses = 0;
    int releases = 0;
    test_reset();
    for (int p = 0; p < 12; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk_sys);
        key1_n_raw = (ph == 0) ? 1'b0 : 1'b1;
        repeat (12) begin
          @(posedge clk_sys); #1;
          if (key1_press === 1'b1) presses++;
          if (key1_release === 1'b1) releases++;
          total++;
          if ((key1_press & key1_release) !== 1'b0) begin
            bad++;
            $display("FAIL odo_strobe_overlap pair=%0d got=11 want=not both", p);
          end
        end
      end
    end
    total++;
    if (presses != 12 || releases != 12) begin
      bad++;
      $display("FAIL odo_strobes got=%0d/%0d want=12/12", presses, releases);
    end
    total++;
    if ({odo_huns, odo_tens, odo_units} !== 12'h012) begin
      bad++;
      $display("FAIL odo_count got=%h want=012", {odo_huns, odo_tens, odo_units});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_sys);
    key1_n_raw = 1'b0;
    repeat (8) @(posedge clk_sys);
    #3;
    rst_n_key0 = 1'b0;
    #1;
    total++;
    if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
      bad++;
      $display("FAIL midq_reset got=%b want=000", {key1_stable, key1_press, key1_release});
    end
    @(negedge clk_sys);
    rst_n_key0 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic exp_st, exp_pr;
      @(posedge clk_sys); #1;
      exp_st = (k >= 11);
      exp_pr = (k == 11);
      total++;
      if ({key1_stable, key1_press, key1_release} !== {exp_st, exp_pr, 1'b0}) begin
        bad++;
        $display("FAIL post_reset_press edge=%0d got=%b want=%b", k,
                 {key1_stable, key1_press, key1_release}, {exp_st, exp_pr, 1'b0});
      end
    end
    #2;
    rst_n_key0 = 1'b0;
    #1;
    total++;
    if (key1_stable !== 1'b0) begin
      bad++;
      $display("FAIL pressed_async_reset got=%b want=0", key1_stable);
    end
    repeat (2) @(posedge clk_sys);
    #1;
    total++;
    if ({key1_stable, key1_press, key1_release} !== 3'b000) begin
      bad++;
      $display("FAIL held_in_reset got=%b want=000", {key1_stable, key1_press, key1_release});
    end
    @(negedge clk_sys);
    rst_n_key0 = 1'b1;
    key1_n_raw = 1'b1;
    repeat (3) @(posedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_press();
    test_clean_release();
    test_bounce_press();
    test_bounce_release();
    test_odometer();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
